// File: rtl/cpu_control_unit.sv
// Multi-cycle FETCH/DECODE/EXEC/WB controller for the 8-bit CPU.
// Decodes one instruction per handshake into ALU and register-file controls and owns the PC.
module cpu_control_unit #(
  parameter int unsigned PC_WIDTH = 32
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [31:0]         INSTRUCTION,
  input  logic                INSTR_VALID,
  output logic                INSTR_READY,
  input  logic                ZERO,
  output logic [2:0]          ALUOP,
  output logic                IMM_SEL,
  output logic                NEG_SEL,
  output logic [7:0]          IMMEDIATE,
  output logic [2:0]          READ_REG1,
  output logic [2:0]          READ_REG2,
  output logic [2:0]          WRITE_REG,
  output logic                WRITE_ENABLE,
  output logic [PC_WIDTH-1:0] PC,
  output logic                ILLEGAL
);

  localparam logic [1:0] S_FETCH  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_EXEC   = 2'd2;
  localparam logic [1:0] S_WB     = 2'd3;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_ROR = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_SRA = 3'b110;
  localparam logic [2:0] ALU_SLL = 3'b111;

  localparam logic [1:0] BR_NONE   = 2'd0;
  localparam logic [1:0] BR_ALWAYS = 2'd1;
  localparam logic [1:0] BR_EQ     = 2'd2;
  localparam logic [1:0] BR_NE     = 2'd3;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;
  localparam logic [7:0] OP_J     = 8'h06;
  localparam logic [7:0] OP_BEQ   = 8'h07;
  localparam logic [7:0] OP_BNE   = 8'h08;
  localparam logic [7:0] OP_ROR   = 8'h09;
  localparam logic [7:0] OP_MULT  = 8'h0A;
  localparam logic [7:0] OP_SRA   = 8'h0B;
  localparam logic [7:0] OP_SLL   = 8'h0C;
  localparam logic [7:0] OP_SRL   = 8'h0D;

  logic [1:0]          state_q, state_d;
  logic [2:0]          aluop_q, aluop_d;
  logic                imm_sel_q, imm_sel_d;
  logic                neg_sel_q, neg_sel_d;
  logic [7:0]          imm_q, imm_d;
  logic [2:0]          rreg1_q, rreg1_d;
  logic [2:0]          rreg2_q, rreg2_d;
  logic [2:0]          wreg_q, wreg_d;
  logic                we_q, we_d;
  logic                ill_q, ill_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                wr_pend_q, wr_pend_d;
  logic                ill_pend_q, ill_pend_d;
  logic [1:0]          br_kind_q, br_kind_d;
  logic [7:0]          offset_q, offset_d;
  logic                taken_q, taken_d;

  logic [2:0]          dec_aluop;
  logic                dec_imm_sel;
  logic                dec_neg_sel;
  logic [7:0]          dec_imm;
  logic                dec_write;
  logic                dec_illegal;
  logic [1:0]          dec_br_kind;
  logic                handshake;
  logic [PC_WIDTH-1:0] pc_step;
  logic [PC_WIDTH-1:0] br_off;
  logic                unused_instr_bits;

  assign INSTR_READY       = (state_q == S_FETCH) && !RESET;
  assign handshake         = INSTR_VALID && INSTR_READY;
  assign unused_instr_bits = ^INSTRUCTION[15:11];

  // Opcode decode of the incoming word, registered on the handshake edge.
  always_comb begin
    dec_aluop   = ALU_FWD;
    dec_imm_sel = 1'b0;
    dec_neg_sel = 1'b0;
    dec_imm     = INSTRUCTION[7:0];
    dec_write   = 1'b0;
    dec_illegal = 1'b0;
    dec_br_kind = BR_NONE;
    case (INSTRUCTION[31:24])
      OP_LOADI: begin dec_imm_sel = 1'b1; dec_write = 1'b1; end
      OP_MOV:   dec_write = 1'b1;
      OP_ADD:   begin dec_aluop = ALU_ADD; dec_write = 1'b1; end
      OP_SUB:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; dec_write = 1'b1; end
      OP_AND:   begin dec_aluop = ALU_AND; dec_write = 1'b1; end
      OP_OR:    begin dec_aluop = ALU_OR; dec_write = 1'b1; end
      OP_J:     dec_br_kind = BR_ALWAYS;
      OP_BEQ:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; dec_br_kind = BR_EQ; end
      OP_BNE:   begin dec_aluop = ALU_ADD; dec_neg_sel = 1'b1; dec_br_kind = BR_NE; end
      OP_ROR:   begin dec_aluop = ALU_ROR; dec_imm_sel = 1'b1; dec_write = 1'b1; end
      OP_MULT:  begin dec_aluop = ALU_MUL; dec_write = 1'b1; end
      OP_SRA:   begin dec_aluop = ALU_SRA; dec_imm_sel = 1'b1; dec_write = 1'b1; end
      OP_SLL:   begin dec_aluop = ALU_SLL; dec_imm_sel = 1'b1; dec_write = 1'b1; end
      OP_SRL: begin
        dec_aluop   = ALU_SLL;
        dec_imm_sel = 1'b1;
        dec_imm     = 8'(8'd0 - INSTRUCTION[7:0]);
        dec_write   = 1'b1;
      end
      default:  dec_illegal = 1'b1;
    endcase
  end

  assign pc_step = pc_q + PC_WIDTH'(4);
  assign br_off  = PC_WIDTH'($signed({offset_q, 2'b00}));

  // Next-state and next-output logic; controls hold unless a new word is accepted.
  always_comb begin
    state_d    = state_q;
    aluop_d    = aluop_q;
    imm_sel_d  = imm_sel_q;
    neg_sel_d  = neg_sel_q;
    imm_d      = imm_q;
    rreg1_d    = rreg1_q;
    rreg2_d    = rreg2_q;
    wreg_d     = wreg_q;
    we_d       = we_q;
    ill_d      = ill_q;
    pc_d       = pc_q;
    wr_pend_d  = wr_pend_q;
    ill_pend_d = ill_pend_q;
    br_kind_d  = br_kind_q;
    offset_d   = offset_q;
    taken_d    = taken_q;
    case (state_q)
      S_FETCH: begin
        we_d  = 1'b0;
        ill_d = 1'b0;
        if (handshake) begin
          state_d    = S_DECODE;
          aluop_d    = dec_aluop;
          imm_sel_d  = dec_imm_sel;
          neg_sel_d  = dec_neg_sel;
          imm_d      = dec_imm;
          rreg1_d    = INSTRUCTION[10:8];
          rreg2_d    = INSTRUCTION[2:0];
          wreg_d     = INSTRUCTION[18:16];
          wr_pend_d  = dec_write;
          ill_pend_d = dec_illegal;
          br_kind_d  = dec_br_kind;
          offset_d   = INSTRUCTION[23:16];
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_WB;
        we_d    = wr_pend_q;
        ill_d   = ill_pend_q;
        // ZERO is only trusted here, after the ALU has had DECODE+EXEC to settle.
        taken_d = (br_kind_q == BR_ALWAYS) ||
                  ((br_kind_q == BR_EQ) && ZERO) ||
                  ((br_kind_q == BR_NE) && !ZERO);
      end
      default: begin
        state_d = S_FETCH;
        we_d    = 1'b0;
        ill_d   = 1'b0;
        pc_d    = taken_q ? (pc_step + br_off) : pc_step;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= S_FETCH;
      aluop_q    <= ALU_FWD;
      imm_sel_q  <= 1'b0;
      neg_sel_q  <= 1'b0;
      imm_q      <= 8'd0;
      rreg1_q    <= 3'd0;
      rreg2_q    <= 3'd0;
      wreg_q     <= 3'd0;
      we_q       <= 1'b0;
      ill_q      <= 1'b0;
      pc_q       <= '0;
      wr_pend_q  <= 1'b0;
      ill_pend_q <= 1'b0;
      br_kind_q  <= BR_NONE;
      offset_q   <= 8'd0;
      taken_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      aluop_q    <= aluop_d;
      imm_sel_q  <= imm_sel_d;
      neg_sel_q  <= neg_sel_d;
      imm_q      <= imm_d;
      rreg1_q    <= rreg1_d;
      rreg2_q    <= rreg2_d;
      wreg_q     <= wreg_d;
      we_q       <= we_d;
      ill_q      <= ill_d;
      pc_q       <= pc_d;
      wr_pend_q  <= wr_pend_d;
      ill_pend_q <= ill_pend_d;
      br_kind_q  <= br_kind_d;
      offset_q   <= offset_d;
      taken_q    <= taken_d;
    end
  end

  assign ALUOP        = aluop_q;
  assign IMM_SEL      = imm_sel_q;
  assign NEG_SEL      = neg_sel_q;
  assign IMMEDIATE    = imm_q;
  assign READ_REG1    = rreg1_q;
  assign READ_REG2    = rreg2_q;
  assign WRITE_REG    = wreg_q;
  assign WRITE_ENABLE = we_q;
  assign ILLEGAL      = ill_q;
  assign PC           = pc_q;

endmodule
